// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port, decode-side
// valid/ready port, and the branch-redirect and halt status signals.
interface instruction_fetch_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [3:0]         if_opcode;
  logic [ADDR_W-1:0]  if_pc;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halted;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output if_valid, if_instr, if_opcode, if_pc,
    input  id_ready,
    input  redirect, redirect_pc,
    output halted
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  if_valid, if_instr, if_opcode, if_pc,
    output id_ready,
    output redirect, redirect_pc,
    input  halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, instruction-memory request/ack, instruction register
// for decode, branch redirect with squash of in-flight data, HALT stop.
//
// state | meaning
// IDLE  | one cycle after reset, latches first fetch address
// WAIT  | request outstanding, data will be kept
// FULL  | instruction register valid for decode
// DROP  | request outstanding, data will be discarded (redirected)
// HALT  | fetch stopped until reset
module instruction_fetch #(
  parameter int               ADDR_W   = 8,
  parameter int               INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]       HALT_OP  = 4'hF
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_FULL = 3'd2,
    S_DROP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic               imem_req_q, imem_req_d;
  logic               if_valid_q, if_valid_d;
  logic               halted_q, halted_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    case (state_q)
      S_IDLE: begin
        req_addr_d = pc_q;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_ack && !bus.redirect) begin
          ir_d    = bus.imem_rdata;
          ir_pc_d = req_addr_q;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_FULL;
        end else if (bus.imem_ack && bus.redirect) begin
          pc_d       = bus.redirect_pc;
          req_addr_d = bus.redirect_pc;
        end else if (bus.redirect) begin
          // outstanding request must still complete at the old address
          pc_d    = bus.redirect_pc;
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.redirect) pc_d = bus.redirect_pc;
        if (bus.imem_ack) begin
          req_addr_d = pc_d;
          state_d    = S_WAIT;
        end
      end
      S_FULL: begin
        if (bus.redirect) begin
          pc_d       = bus.redirect_pc;
          req_addr_d = bus.redirect_pc;
          state_d    = S_WAIT;
        end else if (bus.id_ready) begin
          if (ir_q[INSTR_W-1 -: 4] == HALT_OP) begin
            state_d = S_HALT;
          end else begin
            req_addr_d = pc_q;
            state_d    = S_WAIT;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    imem_req_d = (state_d == S_WAIT) || (state_d == S_DROP);
    if_valid_d = (state_d == S_FULL);
    halted_d   = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      imem_req_q <= 1'b0;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      imem_req_q <= imem_req_d;
      if_valid_q <= if_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = req_addr_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = ir_q;
  assign bus.if_opcode = ir_q[INSTR_W-1 -: 4];
  assign bus.if_pc     = ir_pc_q;
  assign bus.halted    = halted_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the CPU: holds the program counter, issues requests to instruction memory over a req/ack handshake, and registers each returned word. It presents the word to the decode stage together with its 4-bit opcode field, which drives control_unit_M's `opcode` input. It accepts branch redirects from downstream and stops fetching after a HALT instruction.

## Interface

**Parameters**
- `ADDR_W`, default 8: PC and instruction-memory address width.
- `INSTR_W`, default 16: instruction width; opcode is bits `[INSTR_W-1:INSTR_W-4]`.
- `RESET_PC`, default 0: PC value loaded on reset.
- `HALT_OP`, default 4'hF: opcode that halts fetch.

**Ports**
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `imem_req`, output, 1: fetch request; held high until `imem_ack`.
- `imem_addr`, output, ADDR_W: fetch address; stable while `imem_req` is high.
- `imem_ack`, input, 1: read data valid this cycle; may be high in the first cycle of `imem_req`.
- `imem_rdata`, input, INSTR_W: instruction word, sampled when `imem_ack` is high.
- `if_valid`, output, 1: `if_instr`, `if_opcode` and `if_pc` are valid.
- `id_ready`, input, 1: decode accepts the word when `if_valid && id_ready`.
- `if_instr`, output, INSTR_W: registered instruction.
- `if_opcode`, output, 4: `if_instr[INSTR_W-1:INSTR_W-4]`; feeds control_unit_M `opcode`.
- `if_pc`, output, ADDR_W: address of `if_instr`.
- `redirect`, input, 1: branch taken; load `redirect_pc`.
- `redirect_pc`, input, ADDR_W: branch target.
- `halted`, output, 1: fetch is stopped after HALT.

## Operation

**Registers:** `pc` (next fetch address), `req_addr`, `ir`, `ir_pc`, `state`.

**States:** IDLE, WAIT, FULL, DROP, HALT.

**Outputs by state**
- `imem_req` = 1 in WAIT or DROP; `imem_addr` = `req_addr`.
- `if_valid` = 1 only in FULL.
- `halted` = 1 only in HALT.

**IDLE:** the state after reset. Next cycle: `req_addr <= pc`, go to WAIT.

**WAIT**
- `imem_ack && !redirect`: `ir <= imem_rdata`, `ir_pc <= req_addr`, `pc <= pc+1` (mod 2^ADDR_W, so 0xFF wraps to 0x00), go to FULL.
- `imem_ack && redirect`: discard the data, `pc <= redirect_pc`, `req_addr <= redirect_pc`, stay in WAIT.
- `!imem_ack && redirect`: `pc <= redirect_pc`, go to DROP. `req_addr` is unchanged, so the outstanding request completes.

**DROP:** on `imem_ack`, discard the data, `req_addr <= pc`, go to WAIT. A further `redirect` in DROP only updates `pc`.

**FULL**
- `redirect` has priority: the held word is squashed and not transferred even if `id_ready` is high. `pc <= redirect_pc`, `req_addr <= redirect_pc`, go to WAIT.
- Otherwise, on `id_ready`: if `if_opcode == HALT_OP`, go to HALT. Else `req_addr <= pc`, go to WAIT.
- Otherwise: hold; `ir` and `ir_pc` stay stable.

**HALT:** terminal until `rst_n` is asserted. `redirect` is ignored.

**Reset (asynchronous, any state, including mid-request):**
- `pc` = `RESET_PC`, `state` = IDLE.
- `ir` = 0, so `if_opcode` = 0; `ir_pc` = 0; `req_addr` = `RESET_PC`.
- Outputs: `imem_req`=0, `if_valid`=0, `halted`=0.
- An ack for a request cut off by reset is not tracked; memory must also be reset.

## Timing

- Minimum fetch period is 2 cycles per instruction (WAIT then FULL) with zero-wait memory. With k wait cycles it is k+2.
- First `imem_req` is asserted in the 2nd cycle after `rst_n` deasserts (IDLE lasts 1 cycle).
- `if_valid` rises the cycle after the accepting `imem_ack`. Latency from request to valid is (ack cycles)+1.
- After a redirect, the new request is issued the next cycle if no request is outstanding. If one is outstanding, it is issued the cycle after its ack.
- All outputs are registered or decoded from `state` only. There is no combinational path from `imem_ack`, `id_ready` or `redirect` to any output.

## Test plan

1. **Reset and zero-wait stream:** hold `rst_n`=0 → all outputs 0, `if_opcode`=0. Release with memory returning `{op=1,0}`, `{op=8,0}`, `{op=9,0}` at addresses 0, 1, 2 with ack in the request cycle → `if_opcode` sequence 1, 8, 9 with `if_pc` 0, 1, 2; `if_valid` high every other cycle.
2. **Wait states and backpressure:** ack 3 cycles after req, `id_ready`=0 for 4 cycles → `imem_addr` stable for 4 req cycles; `if_instr` held unchanged; no new `imem_req` until the transfer.
3. **Redirect in WAIT:** redirect to 0x40 two cycles into a pending fetch of 0x05 → DROP; the 0x05 data is never valid; next request addr 0x40; `if_pc`=0x40.
4. **Redirect with ack, and redirect with id_ready in FULL:** both cycles → data discarded, no transfer; next request at `redirect_pc`.
5. **Wrap and halt:** `RESET_PC`=0xFE, memory op 0x3 at 0xFE, 0x3 at 0xFF, 0xF at 0x00 → `if_pc` 0xFE, 0xFF, 0x00. After the HALT word is accepted, `halted`=1, `imem_req` stays 0, and a redirect is ignored.
6. **Reset mid-request:** assert `rst_n`=0 while `imem_req`=1 and `if_valid`=0 → `imem_req` drops immediately (asynchronously); after release, refetch from `RESET_PC`.
